hmmm_muldiv: RTL and testbench

//  Iterative signed multiply/divide/modulo unit for the HMMM core's MUL, DIV and MOD instructions.

---
 rtl/hmmm_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_hmmm_muldiv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmmm_muldiv.sv
// Iterative signed MUL/DIV/MOD unit: operand magnitudes are processed one bit per cycle,
// then a single fix-up cycle applies signs (floor semantics for DIV/MOD) and flags.
module hmmm_muldiv #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_dbz,
   output logic             res_ovf,
   output logic [1:0]       dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // once raised, res_valid and its payload stay put until res_ready is seen.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_DIV = 2'd1;
   localparam logic [1:0] OP_MOD = 2'd2;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   res_data_q, res_data_d;
   logic [TAG_W-1:0]   res_tag_q, res_tag_d;
   logic               res_dbz_q, res_dbz_d, res_ovf_q, res_ovf_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     msum, trial, dsub;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
   logic [WIDTH:0]     prod_top;
   logic [WIDTH-1:0]   q_u, r_u, q_t, r_t, q_f, r_f;
   logic               a_neg, b_neg, neg, corr, mul_ovf, is_dbz, min_ovf, ge;
   logic [WIDTH-1:0]   fix_data;
   logic               fix_ovf, fix_dbz;

   assign mag_a = in_a[WIDTH-1] ? -in_a : in_a;
   assign mag_b = in_b[WIDTH-1] ? -in_b : in_b;

   // Shift-add: acc holds {partial product, remaining multiplier bits}.
   assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign mul_next = {msum, acc_q[WIDTH-1:1]};

   // Restoring division: acc holds {remainder, dividend bits shifting out / quotient bits in}.
   assign trial    = acc_q[2*WIDTH-1:WIDTH-1];
   assign dsub     = trial - {1'b0, opnd_q};
   assign ge       = ~dsub[WIDTH];
   assign div_next = {(ge ? dsub[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};

   assign a_neg    = a_q[WIDTH-1];
   assign b_neg    = b_q[WIDTH-1];
   assign neg      = a_neg ^ b_neg;
   assign prod_s   = neg ? -acc_q : acc_q;
   assign prod_top = prod_s[2*WIDTH-1:WIDTH-1];
   assign mul_ovf  = ~((&prod_top) | ~(|prod_top));
   assign q_u      = acc_q[WIDTH-1:0];
   assign r_u      = acc_q[2*WIDTH-1:WIDTH];
   assign q_t      = neg ? -q_u : q_u;
   assign r_t      = a_neg ? -r_u : r_u;
   // Floor correction turns truncated results into round-toward-minus-infinity.
   assign corr     = neg && (r_u != {WIDTH{1'b0}});
   assign q_f      = corr ? q_t - WIDTH'(1) : q_t;
   assign r_f      = corr ? r_t + b_q : r_t;
   assign is_dbz   = (b_q == {WIDTH{1'b0}});
   assign min_ovf  = (a_q == MIN_VAL) && (&b_q);

   always_comb begin
      fix_data = '0;
      fix_ovf  = 1'b0;
      fix_dbz  = 1'b0;
      case (op_q)
         OP_MUL: begin
            fix_data = prod_s[WIDTH-1:0];
            fix_ovf  = mul_ovf;
         end
         OP_DIV: begin
            fix_dbz  = is_dbz;
            fix_ovf  = !is_dbz && min_ovf;
            fix_data = is_dbz ? '0 : (min_ovf ? MIN_VAL : q_f);
         end
         OP_MOD: begin
            fix_dbz  = is_dbz;
            fix_data = is_dbz ? a_q : r_f;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      tag_d      = tag_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      res_data_d = res_data_q;
      res_tag_d  = res_tag_q;
      res_dbz_d  = res_dbz_q;
      res_ovf_d  = res_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               cnt_d   = '0;
               op_d    = in_op;
               a_d     = in_a;
               b_d     = in_b;
               tag_d   = in_tag;
               opnd_d  = (in_op == OP_MUL) ? mag_a : mag_b;
               acc_d   = {{WIDTH{1'b0}}, ((in_op == OP_MUL) ? mag_b : mag_a)};
            end
         end
         S_RUN: begin
            acc_d = (op_q == OP_MUL) ? mul_next : div_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end
         end
         S_FIX: begin
            state_d    = S_DONE;
            res_data_d = fix_data;
            res_tag_d  = tag_q;
            res_dbz_d  = fix_dbz;
            res_ovf_d  = fix_ovf;
         end
         default: begin
            if (res_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         tag_q      <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         res_data_q <= '0;
         res_tag_q  <= '0;
         res_dbz_q  <= 1'b0;
         res_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         tag_q      <= tag_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         res_data_q <= res_data_d;
         res_tag_q  <= res_tag_d;
         res_dbz_q  <= res_dbz_d;
         res_ovf_q  <= res_ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign res_valid = (state_q == S_DONE);
   assign res_data  = res_data_q;
   assign res_tag   = res_tag_q;
   assign res_dbz   = res_dbz_q;
   assign res_ovf   = res_ovf_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_hmmm_muldiv.sv
// Bench for hmmm_muldiv: a WIDTH=16 instance with a queue scoreboard and directed/random ops,
// plus a WIDTH=8 instance swept over corner operands against an arithmetic reference model.
module tb_hmmm_muldiv;
   localparam int W = 16, T = 4, W8 = 8, T8 = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic           in_valid, in_ready, res_valid, res_ready, res_dbz, res_ovf;
   logic [1:0]     in_op, dbg_state;
   logic [W-1:0]   in_a, in_b, res_data;
   logic [T-1:0]   in_tag, res_tag;

   logic           in_valid8, in_ready8, res_valid8, res_ready8, res_dbz8, res_ovf8;
   logic [1:0]     in_op8, dbg_state8;
   logic [W8-1:0]  in_a8, in_b8, res_data8;
   logic [T8-1:0]  in_tag8, res_tag8;

   hmmm_muldiv #(.WIDTH(W), .TAG_W(T)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag), .res_dbz(res_dbz), .res_ovf(res_ovf),
      .dbg_state(dbg_state));

   hmmm_muldiv #(.WIDTH(W8), .TAG_W(T8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
      .in_a(in_a8), .in_b(in_b8), .in_tag(in_tag8), .res_valid(res_valid8),
      .res_ready(res_ready8), .res_data(res_data8), .res_tag(res_tag8), .res_dbz(res_dbz8),
      .res_ovf(res_ovf8), .dbg_state(dbg_state8));

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint sx(int w, logic [31:0] x);
      longint v = 0;
      for (int i = 0; i < w; i++) v[i] = x[i];
      if (x[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   // Returns {dbz, ovf, data[31:0]} using plain integer arithmetic with floor semantics.
   function automatic logic [33:0] ref_op(int w, logic [1:0] op, longint a, longint b);
      longint mn = -(longint'(1) << (w - 1));
      longint mx = (longint'(1) << (w - 1)) - 1;
      longint p, q, r, d;
      logic dbz = 1'b0, ovf = 1'b0;
      d = 0;
      case (op)
         2'd0: begin
            p = a * b;
            d = p;
            ovf = (p > mx) || (p < mn);
         end
         2'd1: begin
            if (b == 0) dbz = 1'b1;
            else if (a == mn && b == -1) begin d = mn; ovf = 1'b1; end
            else begin
               q = a / b;
               r = a % b;
               if (r != 0 && ((r < 0) != (b < 0))) q = q - 1;
               d = q;
            end
         end
         2'd2: begin
            if (b == 0) begin dbz = 1'b1; d = a; end
            else begin
               r = a % b;
               if (r != 0 && ((r < 0) != (b < 0))) r = r + b;
               d = r;
            end
         end
         default: d = 0;
      endcase
      return {dbz, ovf, d[31:0]};
   endfunction

   // WIDTH=16 scoreboard: {tag, dbz, ovf, data} pushed at accept, popped at result handshake.
   logic [T+2+W-1:0] exp_q[$];
   int acc_q[$];
   bit seen = 1'b0;

   always @(negedge clk) begin
      logic [T+2+W-1:0] e;
      if (!reset) begin
         if (res_valid && !seen) begin
            seen = 1'b1;
            if (acc_q.size() > 0) check_eq("latency16", cyc - acc_q[0], W + 2);
         end
         if (res_valid && res_ready) begin
            check_eq("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (acc_q.size() != 0) void'(acc_q.pop_front());
               check_eq("data16", res_data, e[W-1:0]);
               check_eq("ovf16", res_ovf, e[W]);
               check_eq("dbz16", res_dbz, e[W+1]);
               check_eq("tag16", res_tag, e[T+W+1:W+2]);
            end
            seen = 1'b0;
         end
      end
   end

   task automatic issue16(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [T-1:0] tag,
                          logic [33:0] r);
      int n = 0;
      bit took = 1'b0;
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      while (!took && n < 200) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("accept16", took, 1);
      if (took) begin
         exp_q.push_back({tag, r[33], r[32], r[W-1:0]});
         acc_q.push_back(cyc - 1);
      end
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_op = 2'($urandom);
   endtask

   task automatic issue16_model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [T-1:0] tag);
      issue16(op, a, b, tag, ref_op(W, op, sx(W, a), sx(W, b)));
   endtask

   task automatic drain16();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("drain16", exp_q.size(), 0);
   endtask

   task automatic op8(logic [1:0] op, logic [W8-1:0] a, logic [W8-1:0] b, logic [T8-1:0] tag);
      logic [T8+2+W8-1:0] exp8_q[$];
      logic [T8+2+W8-1:0] e;
      logic [33:0] r;
      int n = 0;
      int acc;
      bit took = 1'b0;
      r = ref_op(W8, op, sx(W8, a), sx(W8, b));
      in_op8 = op; in_a8 = a; in_b8 = b; in_tag8 = tag; in_valid8 = 1'b1;
      while (!took && n < 50) begin
         @(negedge clk);
         took = in_ready8;
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("accept8", took, 1);
      in_valid8 = 1'b0;
      in_a8 = W8'($urandom);
      in_b8 = W8'($urandom);
      if (took) begin
         exp8_q.push_back({tag, r[33], r[32], r[W8-1:0]});
         acc = cyc - 1;
         n = 0;
         while (!res_valid8 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         check_eq("latency8", cyc - acc, W8 + 2);
         e = exp8_q.pop_front();
         check_eq("data8", res_data8, e[W8-1:0]);
         check_eq("ovf8", res_ovf8, e[W8]);
         check_eq("dbz8", res_dbz8, e[W8+1]);
         check_eq("tag8", res_tag8, e[T8+W8+1:W8+2]);
         @(posedge clk);
         #1;
      end
   endtask

   logic [1:0]   d_op[14]   = '{0, 0, 1, 2, 2, 1, 1, 2, 1, 2, 0, 0, 3, 0};
   logic [W-1:0] d_a[14]    = '{300, 16'hFFFD, 16'hFFF9, 16'hFFF9, 7, 7, 5, 5,
                                16'h8000, 16'h8000, 16'h8000, 16'h8000, 5, 16'hFF00};
   logic [W-1:0] d_b[14]    = '{200, 7, 2, 2, 16'hFFFE, 2, 0, 0,
                                16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 3, 16'h0100};
   logic [W-1:0] d_res[14]  = '{16'hEA60, 16'hFFEB, 16'hFFFC, 1, 16'hFFFF, 3, 0, 5,
                                16'h8000, 0, 16'h8000, 16'h8000, 0, 0};
   logic         d_ovf[14]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1};
   logic         d_dbz[14]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
   logic [W8-1:0] v8[12]    = '{0, 1, 2, 3, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'hFE, 8'h55, 8'h40, 8'hC0};

   initial begin
      int vcount;
      reset = 1'b1;
      in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; res_ready = 1'b1;
      in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0; in_tag8 = '0; res_ready8 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_res_data", res_data, 0);
      check_eq("rst_res_tag", res_tag, 0);
      check_eq("rst_flags", {res_dbz, res_ovf}, 0);
      check_eq("rst_state", dbg_state, 0);

      // Directed cases with hand-derived expectations.
      for (int i = 0; i < 14; i++) begin
         issue16(d_op[i], d_a[i], d_b[i], T'(i) ^ 4'hA,
                 {d_dbz[i], d_ovf[i], 16'h0, d_res[i]});
         drain16();
      end

      // Backpressure: hold the result for 5 cycles while a new request is offered.
      res_ready = 1'b0;
      issue16(0, 300, 200, 4'h6, {2'b01, 16'h0, 16'hEA60});
      vcount = 0;
      while (!res_valid && vcount < 40) begin
         @(posedge clk);
         #1;
         vcount++;
      end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_op = 2'd1; in_a = W'($urandom); in_b = W'($urandom); in_tag = 4'h9;
         @(posedge clk);
         #1;
         check_eq("bp_valid", res_valid, 1);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_data", res_data, 16'hEA60);
         check_eq("bp_tag", res_tag, 4'h6);
         check_eq("bp_ovf", res_ovf, 1);
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_ready_after", in_ready, 1);
      check_eq("bp_valid_drop", res_valid, 0);
      check_eq("bp_hold_data", res_data, 16'hEA60);
      vcount = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         vcount += int'(res_valid);
      end
      check_eq("bp_no_ghost", vcount, 0);

      // Reset during RUN cycle 7 discards the operation.
      issue16_model(0, 1234, 16'hFFC8, 4'h3);
      repeat (6) @(posedge clk);
      #1;
      check_eq("mid_run_state", dbg_state, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
      check_eq("rr_in_ready", in_ready, 1);
      check_eq("rr_res_valid", res_valid, 0);
      check_eq("rr_res_data", res_data, 0);
      check_eq("rr_res_tag", res_tag, 0);
      check_eq("rr_flags", {res_dbz, res_ovf}, 0);
      vcount = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         vcount += int'(res_valid);
      end
      check_eq("rr_no_valid", vcount, 0);
      issue16(1, 16'hFFF9, 2, 4'hC, {2'b00, 16'h0, 16'hFFFC});
      drain16();

      // Random WIDTH=16 traffic against the reference model.
      for (int i = 0; i < 120; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 16'h8000;
         if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
         issue16_model(2'($urandom_range(0, 3)), ra, rb, T'($urandom));
         drain16();
      end

      // WIDTH=8 corner sweep over every op, then random operands.
      for (int o = 0; o < 4; o++)
         for (int i = 0; i < 12; i++)
            for (int j = 0; j < 12; j++)
               op8(2'(o), v8[i], v8[j], T8'(i + j));
      for (int i = 0; i < 200; i++)
         op8(2'($urandom_range(0, 3)), W8'($urandom), W8'($urandom_range(0, 255)), T8'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
